// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and sends them as 8N1 (or 8E1) UART frames.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d, tx_q, tx_d, done_q, done_d;
  logic        last, serial;
  always_comb begin
    last    = cnt_q == 16'(CLKS_PER_BIT - 1);
    serial  = state_q inside {START, DATA, PARITY, STOP};
    // the counter only advances while a bit is on the line and restarts on every bit boundary
    cnt_d   = (serial && !last) ? cnt_q + 16'd1 : 16'd0;
    tx_d    = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
    done_d  = state_q == STOP && last;
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE:   state_d = (en && !fifo_empty) ? POP : IDLE;
      POP:    state_d = LOAD;
      LOAD: begin
        shift_d = fifo_dout;
        par_d   = ^fifo_dout;
        bit_d   = 3'd0;
        state_d = START;
      end
      START:  state_d = last ? DATA : START;
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      end
      PARITY: state_d = last ? STOP : PARITY;
      STOP:   state_d = last ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
  assign fifo_rd    = state_q == POP;
  assign busy       = state_q != IDLE;
  assign tx         = tx_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for a no-parity and an even-parity transmitter with a byte scoreboard.
module tb_fifo_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = 2'b00;
  logic [1:0] empty, rd, tx, busy, done;
  logic [7:0] dout [2];
  logic [7:0] mem [2][16];
  int         wp [2] = '{0, 0};
  int         rp [2] = '{0, 0};
  int         rd_cnt [2] = '{0, 0};
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
    .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
    .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));

  assign empty = {wp[1] == rp[1], wp[0] == rp[0]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++)
      if (rd[i] === 1'b1) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        if (rp[i] != wp[i]) begin
          dout[i] <= mem[i][rp[i][3:0]];
          rp[i]   <= rp[i] + 1;
        end
      end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] b, input bit sb);
    mem[s][wp[s][3:0]] = b;
    wp[s] = wp[s] + 1;
    if (sb) begin
      if (s == 0) exp0.push_back(b);
      else exp1.push_back(b);
    end
  endtask

  // walks a whole frame cycle by cycle; drop>0 deasserts en at that frame cycle
  task automatic rx(input int s, input int drop, output int t0);
    int n, glitch, dcnt, dpos, fc, sz;
    logic [10:0] bits;
    logic [7:0]  e;
    n = (s == 1) ? 11 : 10;
    glitch = 0; dcnt = 0; dpos = 0; bits = '0; t0 = -1;
    for (int k = 0; k < 300 && tx[s] !== 1'b0; k++) @(negedge clk);
    chk("frame_start", 32'(tx[s]), 0);
    if (tx[s] !== 1'b0) return;
    t0 = cyc;
    for (int b = 0; b < n; b++)
      for (int c = 0; c < 4; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        fc = 4 * b + c + 1;
        if (fc == drop) en[s] = 1'b0;
        if (c == 0) bits[b] = tx[s];
        else if (tx[s] !== bits[b]) glitch++;
        if (done[s] === 1'b1) begin
          dcnt++;
          dpos = fc;
        end
      end
    chk("bit_stable", glitch, 0);
    chk("start_bit", 32'(bits[0]), 0);
    chk("stop_bit", 32'(bits[n-1]), 1);
    chk("done_count", dcnt, 1);
    chk("done_pos", dpos, 4 * n);
    sz = (s == 1) ? exp1.size() : exp0.size();
    chk("sb_nonempty", 32'(sz > 0), 1);
    if (sz > 0) begin
      e = (s == 1) ? exp1.pop_front() : exp0.pop_front();
      chk("data", 32'(bits[8:1]), 32'(e));
      if (s == 1) chk("parity", 32'(bits[9]), 32'(^e));
    end
  endtask

  initial begin
    int c0, r0, ta, tb, tc, viol;
    repeat (3) @(negedge clk);
    chk("rst_outs0", {tx[0], busy[0], rd[0], done[0]}, 4'b1000);
    chk("rst_outs1", {tx[1], busy[1], rd[1], done[1]}, 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    // single 0xA5 frame, first-bit latency, one pop
    c0 = cyc; r0 = rd_cnt[0];
    push(0, 8'hA5, 1'b1);
    en[0] = 1'b1;
    rx(0, 0, ta);
    chk("latency_a5", ta - (c0 + 1), 3);
    chk("rd_a5", rd_cnt[0] - r0, 1);
    // even parity: 0x07 -> 1, 0x03 -> 0, back to back at 11 bit periods
    push(1, 8'h07, 1'b1);
    push(1, 8'h03, 1'b1);
    en[1] = 1'b1;
    rx(1, 0, ta);
    rx(1, 0, tb);
    chk("spacing_par", tb - ta, 47);
    en[1] = 1'b0;
    // three back-to-back bytes
    repeat (5) @(negedge clk);
    c0 = cyc; r0 = rd_cnt[0];
    push(0, 8'h55, 1'b1);
    push(0, 8'hAA, 1'b1);
    push(0, 8'hFF, 1'b1);
    rx(0, 0, ta);
    rx(0, 0, tb);
    rx(0, 0, tc);
    chk("latency_55", ta - (c0 + 1), 3);
    chk("spacing_1", tb - ta, 43);
    chk("spacing_2", tc - tb, 43);
    repeat (4) @(negedge clk);
    chk("rd_three", rd_cnt[0] - r0, 3);
    // empty FIFO with en high: nothing moves
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
    end
    chk("idle_empty", viol, 0);
    // en dropped mid-DATA of 0x3C; frame completes, then no pop while en=0
    r0 = rd_cnt[0];
    push(0, 8'h3C, 1'b1);
    rx(0, 15, ta);
    push(0, 8'h11, 1'b0);
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (rd[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
    end
    chk("idle_en_low", viol, 0);
    chk("rd_3c", rd_cnt[0] - r0, 1);
    // reset during data bit 3 of 0x11 aborts it and the byte is gone
    en[0] = 1'b1;
    for (int k = 0; k < 20 && tx[0] !== 1'b0; k++) @(negedge clk);
    chk("abort_start", 32'(tx[0]), 0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outs", {tx[0], busy[0], rd[0]}, 3'b100);
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
    end
    chk("abort_quiet", viol, 0);
    c0 = cyc;
    push(0, 8'hC3, 1'b1);
    rx(0, 0, ta);
    chk("latency_c3", ta - (c0 + 1), 3);
    chk("sb_drained", exp0.size() + exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
